div_ctrl: RTL

Execute-stage controller for the iterative divider. It accepts DIV/DIVU/REM/REMU requests from the decoded instruction in ex, latches operands and the destination register, and holds the divider's start line for the whole operation. It stalls the pipeline until the divider reports ready, then issues a one-cycle register-file write. A pipeline flush (jump or interrupt) aborts an in-flight operation without writeback.

---
 rtl/div_ctrl_pkg.sv | 23 ++
 rtl/div_ctrl_if.sv | 47 ++++
 rtl/div_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl_pkg : shared widths, M-extension divide funct3 codes and
//                control-line polarities for the divide controller.
// Rev 1.0
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic RstEnable      = 1'b0;
  localparam logic DivStart       = 1'b1;
  localparam logic DivResultReady = 1'b1;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

endpackage

`default_nettype wire

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl_if : request, divider handshake and writeback signals of the
//               execute-stage divide controller.
// Rev 1.0
// ---------------------------------------------------------------------------
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                  div_req_i;
  logic [2:0]            op_i;
  logic [RegBus-1:0]     reg1_rdata_i;
  logic [RegBus-1:0]     reg2_rdata_i;
  logic [RegAddrBus-1:0] reg_waddr_i;
  logic                  flush_i;
  logic                  div_ready_i;
  logic [RegBus-1:0]     div_result_i;

  logic                  div_start_o;
  logic [RegBus-1:0]     div_dividend_o;
  logic [RegBus-1:0]     div_divisor_o;
  logic [2:0]            div_op_o;
  logic [RegAddrBus-1:0] div_reg_waddr_o;
  logic                  hold_o;
  logic                  reg_we_o;
  logic [RegAddrBus-1:0] reg_waddr_o;
  logic [RegBus-1:0]     reg_wdata_o;

  // Controller side
  modport slave (
    input  div_req_i, op_i, reg1_rdata_i, reg2_rdata_i, reg_waddr_i,
           flush_i, div_ready_i, div_result_i,
    output div_start_o, div_dividend_o, div_divisor_o, div_op_o,
           div_reg_waddr_o, hold_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );

  // Pipeline / divider side
  modport master (
    output div_req_i, op_i, reg1_rdata_i, reg2_rdata_i, reg_waddr_i,
           flush_i, div_ready_i, div_result_i,
    input  div_start_o, div_dividend_o, div_divisor_o, div_op_o,
           div_reg_waddr_o, hold_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );

endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_ctrl : execute-stage controller that launches the iterative divider,
//            stalls the pipeline until ready, then issues one writeback.
// Rev 1.0
// ---------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [RegBus-1:0]     dividend_q;
  logic [RegBus-1:0]     divisor_q;
  logic [2:0]            op_q;
  logic [RegAddrBus-1:0] div_waddr_q;
  logic                  reg_we_q;
  logic [RegAddrBus-1:0] reg_waddr_q;
  logic [RegBus-1:0]     reg_wdata_q;

  logic w_accept;
  logic w_wb;
  logic w_start;
  logic w_hold;

  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    w_wb     = 1'b0;
    w_start  = 1'b0;
    w_hold   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.div_req_i && bus.op_i[2] && !bus.flush_i) begin
          w_accept = 1'b1;
          w_hold   = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Start must fall in the ready cycle, else the idle divider re-launches.
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (bus.div_ready_i == DivResultReady) begin
          w_wb    = 1'b1;
          state_d = IDLE;
        end else begin
          w_start = DivStart;
          w_hold  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      op_q        <= '0;
      div_waddr_q <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      reg_we_q <= w_wb;
      if (w_accept) begin
        dividend_q  <= bus.reg1_rdata_i;
        divisor_q   <= bus.reg2_rdata_i;
        op_q        <= bus.op_i;
        div_waddr_q <= bus.reg_waddr_i;
      end
      if (w_wb) begin
        reg_waddr_q <= div_waddr_q;
        reg_wdata_q <= bus.div_result_i;
      end
    end
  end

  assign bus.div_start_o     = w_start;
  assign bus.hold_o          = w_hold;
  assign bus.div_dividend_o  = dividend_q;
  assign bus.div_divisor_o   = divisor_q;
  assign bus.div_op_o        = op_q;
  assign bus.div_reg_waddr_o = div_waddr_q;
  assign bus.reg_we_o        = reg_we_q;
  assign bus.reg_waddr_o     = reg_waddr_q;
  assign bus.reg_wdata_o     = reg_wdata_q;

endmodule

`default_nettype wire
